spker_tone: RTL and testbench

SPKER_TONE -- requirements
Module: spker_tone

---
 rtl/spker_tone.sv | 48 ++++
 tb/tb_spker_tone.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spker_tone.sv
// Square-wave tone generator for a speaker: an 11-bit up-counter reloads from the
// tone preset at terminal count and toggles the registered speaker drive.
module spker_tone (
    input  logic        CLK,
    input  logic        RST,
    input  logic [10:0] TN,
    output logic        SPKS
);

    localparam int unsigned CNT_W = 11;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(2047);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             spks_next;
    logic             rest;
    logic             term;

    assign rest = (TN == TERM);
    assign term = (cnt == TERM);

    // Rest silences immediately; otherwise a half-period ends when the counter reaches all-ones.
    always_comb begin
        cnt_next  = cnt;
        spks_next = SPKS;
        if (rest) begin
            cnt_next  = TERM;
            spks_next = 1'b0;
        end else if (term) begin
            cnt_next  = TN;
            spks_next = ~SPKS;
        end else begin
            cnt_next  = cnt + CNT_W'(1);
        end
    end

    // Reset parks the counter at terminal count so the first tone edge toggles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= TERM;
            SPKS <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            SPKS <= spks_next;
        end
    end

endmodule

// File: tb/tb_spker_tone.sv
// Randomized self-checking bench for spker_tone against a half-period
// countdown model of the speaker output.
module tb_spker_tone;

    logic        CLK;
    logic        RST;
    logic [10:0] TN;
    logic        SPKS;

    spker_tone dut (
        .CLK  (CLK),
        .RST  (RST),
        .TN   (TN),
        .SPKS (SPKS)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: edges remaining until the next toggle, and the expected output level.
    bit model_valid = 1'b0;
    bit exp_spks    = 1'b0;
    int remain      = 1;
    bit prev_spks   = 1'b0;
    int toggles[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [10:0] tn);
        RST = rst;
        TN  = tn;
        @(posedge CLK);
        cyc++;
        if (rst) begin
            exp_spks    = 1'b0;
            remain      = 1;
            model_valid = 1'b1;
        end else if (tn == 11'h7FF) begin
            exp_spks = 1'b0;
            remain   = 1;
        end else begin
            remain--;
            if (remain == 0) begin
                exp_spks = ~exp_spks;
                remain   = 2048 - int'(tn);
            end
        end
        #1;
        if (model_valid) begin
            check("spks", 32'(SPKS), 32'(exp_spks));
            if (SPKS != prev_spks) toggles.push_back(cyc);
            prev_spks = SPKS;
        end
    endtask

    task automatic run(input int n, input logic [10:0] tn);
        for (int i = 0; i < n; i++) step(1'b0, tn);
    endtask

    task automatic do_reset(input int n, input logic [10:0] tn);
        for (int i = 0; i < n; i++) step(1'b1, tn);
        toggles.delete();
    endtask

    // Checks the first toggle lands on the first edge after reset and every later one is evenly spaced.
    task automatic check_intervals(input string tag, input int start, input int half, input int min_n);
        check({tag, "_count"}, 32'(toggles.size() >= min_n), 32'd1);
        if (toggles.size() > 0) check({tag, "_first"}, 32'(toggles[0]), 32'(start + 1));
        for (int i = 1; i < toggles.size(); i++)
            check({tag, "_half"}, 32'(toggles[i] - toggles[i-1]), 32'(half));
    endtask

    logic [10:0] sweep[14] = '{11'h390, 11'h40C, 11'h45C, 11'h4AD, 11'h50A, 11'h55C, 11'h582,
                               11'h5C8, 11'h606, 11'h640, 11'h656, 11'h684, 11'h69A, 11'h6C0};

    initial begin
        int c0;
        logic [10:0] tn;
        int hold;
        RST = 1'b0;
        TN  = 11'h7FF;

        // Rest after reset: output silent, counter parked.
        do_reset(2, 11'h7FF);
        check("reset_spks", 32'(SPKS), 32'd0);
        run(1000, 11'h7FF);
        check("rest_cnt", 32'(dut.cnt), 32'h7FF);
        check("rest_toggles", 32'(toggles.size()), 32'd0);

        // Tone 0x305: three full periods.
        do_reset(2, 11'h305);
        c0 = cyc;
        run(6 * 1275 + 10, 11'h305);
        check_intervals("tone305", c0, 1275, 7);

        // Sweep at 25 us per step; model covers the old-TN first interval.
        foreach (sweep[i]) run(1250, sweep[i]);

        // Boundaries.
        do_reset(1, 11'h7FE);
        c0 = cyc;
        run(21, 11'h7FE);
        check_intervals("min_div", c0, 2, 10);
        do_reset(1, 11'h000);
        c0 = cyc;
        run(3 * 2048 + 5, 11'h000);
        check_intervals("max_div", c0, 2048, 4);

        // Reset mid half-period, then rest mid-tone.
        do_reset(1, 11'h4AD);
        run(300, 11'h4AD);
        step(1'b1, 11'h4AD);
        check("rst_mid_low", 32'(SPKS), 32'd0);
        step(1'b0, 11'h4AD);
        check("rst_mid_high", 32'(SPKS), 32'd1);
        run(100, 11'h4AD);
        step(1'b0, 11'h7FF);
        check("rest_mid", 32'(SPKS), 32'd0);
        step(1'b0, 11'h123);
        check("leave_rest", 32'(SPKS), 32'd1);

        // Random segments with occasional resets and rests.
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 9))
                0:       tn = 11'h7FF;
                1:       tn = 11'h7FE;
                2:       tn = 11'(2047 - $urandom_range(1, 8));
                default: tn = 11'($urandom);
            endcase
            hold = $urandom_range(1, 1500);
            for (int i = 0; i < hold; i++)
                step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, tn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
